// File: rtl/axis_buf_pkg.sv
// Shared encodings for the ping-pong AXI-Stream frame buffer.
package axis_buf_pkg;

    typedef enum logic {
        W_FILL = 1'b0,
        W_DROP = 1'b1
    } wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_FETCH = 2'd1,
        R_SEND  = 2'd2
    } rd_state_e;

    localparam logic REV_OFF = 1'b0;
    localparam logic REV_ON  = 1'b1;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port with 1-cycle latency.
module sdp_ram #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_BITS  = 11
) (
    input  logic                  aclk,
    input  logic                  we,
    input  logic [ADDR_BITS-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_BITS-1:0]  raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    // Sized to the full {bank, offset} address space so non-power-of-two depths stay in range.
    logic [DATA_WIDTH-1:0] mem [2**ADDR_BITS];

    always_ff @(posedge aclk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge aclk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/axis_pingpong_frame_buffer.sv
// Two-bank AXI-Stream frame buffer: one bank fills while the other plays back,
// forward or reversed, with truncation of frames longer than DEPTH.
module axis_pingpong_frame_buffer
    import axis_buf_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 768
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  cfg_reverse,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  overflow,
    output logic [1:0]            bank_full
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned LEN_W  = ADDR_W + 1;

    wr_state_e              wr_state_q, wr_state_d;
    logic                   wr_sel_q, wr_sel_d;
    logic [ADDR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [1:0]             full_q, full_d, wr_set, rd_clr;
    logic [1:0][LEN_W-1:0]  len_q, len_d;
    logic [1:0]             rev_q, rev_d;
    logic                   overflow_q, overflow_d;
    logic                   s_ready, ram_we;

    rd_state_e              rd_state_q, rd_state_d;
    logic                   rd_sel_q, rd_sel_d;
    logic [LEN_W-1:0]       rd_cnt_q, rd_cnt_d, rd_len;
    logic [ADDR_W-1:0]      rd_off;
    logic                   rd_last, ram_re, ram_valid_q, ram_last_q, ram_last_d;
    logic [DATA_WIDTH-1:0]  ram_rdata;
    logic                   pop, credit;
    logic [1:0]             occupancy;
    logic                   head_v_q, head_v_d, head_last_q, head_last_d;
    logic                   skid_v_q, skid_v_d, skid_last_q, skid_last_d;
    logic [DATA_WIDTH-1:0]  head_data_q, head_data_d, skid_data_q, skid_data_d;

    sdp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_BITS  (LEN_W)
    ) u_ram (
        .aclk  (aclk),
        .we    (ram_we),
        .waddr ({wr_sel_q, wr_ptr_q}),
        .wdata (s_axis_tdata),
        .re    (ram_re),
        .raddr ({rd_sel_q, rd_off}),
        .rdata (ram_rdata)
    );

    always_comb begin
        wr_state_d = wr_state_q;
        wr_sel_d   = wr_sel_q;
        wr_ptr_d   = wr_ptr_q;
        len_d      = len_q;
        rev_d      = rev_q;
        overflow_d = 1'b0;
        wr_set     = 2'b00;
        ram_we     = 1'b0;
        s_ready    = 1'b0;
        unique case (wr_state_q)
            W_FILL: begin
                s_ready = !full_q[wr_sel_q];
                if (s_axis_tvalid && s_ready) begin
                    ram_we = 1'b1;
                    if (wr_ptr_q == '0) begin
                        rev_d[wr_sel_q] = cfg_reverse;
                    end
                    if (s_axis_tlast || wr_ptr_q == ADDR_W'(DEPTH - 1)) begin
                        wr_set[wr_sel_q] = 1'b1;
                        len_d[wr_sel_q]  = LEN_W'(wr_ptr_q) + LEN_W'(1);
                        wr_sel_d         = !wr_sel_q;
                        wr_ptr_d         = '0;
                        if (!s_axis_tlast) begin
                            overflow_d = 1'b1;
                            wr_state_d = W_DROP;
                        end
                    end else begin
                        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                    end
                end
            end
            W_DROP: begin
                s_ready = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) begin
                    wr_state_d = W_FILL;
                end
            end
        endcase
    end

    // A read is only issued when the 2-entry FIFO is guaranteed room for it next cycle.
    assign pop       = head_v_q && m_axis_tready;
    assign occupancy = {1'b0, head_v_q} + {1'b0, skid_v_q} + {1'b0, ram_valid_q} - {1'b0, pop};
    assign credit    = occupancy <= 2'd1;
    assign rd_len    = len_q[rd_sel_q];
    assign rd_last   = rd_cnt_q == rd_len - LEN_W'(1);
    assign rd_off    = (rev_q[rd_sel_q] == REV_ON) ? ADDR_W'(rd_len - LEN_W'(1) - rd_cnt_q)
                                                   : ADDR_W'(rd_cnt_q);

    always_comb begin
        rd_state_d = rd_state_q;
        rd_sel_d   = rd_sel_q;
        rd_cnt_d   = rd_cnt_q;
        rd_clr     = 2'b00;
        ram_re     = 1'b0;
        unique case (rd_state_q)
            R_IDLE: begin
                if (full_q[rd_sel_q]) begin
                    rd_cnt_d   = '0;
                    rd_state_d = R_FETCH;
                end
            end
            R_FETCH: begin
                ram_re     = 1'b1;
                rd_cnt_d   = LEN_W'(1);
                rd_state_d = R_SEND;
            end
            R_SEND: begin
                ram_re = credit && (rd_cnt_q != rd_len);
                if (ram_re) begin
                    rd_cnt_d = rd_cnt_q + LEN_W'(1);
                end
                if (pop && head_last_q) begin
                    rd_clr[rd_sel_q] = 1'b1;
                    rd_sel_d         = !rd_sel_q;
                    rd_state_d       = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
        ram_last_d = ram_re && rd_last;
    end

    // Head register drives the output port directly; skid catches the in-flight read.
    always_comb begin
        head_v_d    = head_v_q;
        head_last_d = head_last_q;
        head_data_d = head_data_q;
        skid_v_d    = skid_v_q;
        skid_last_d = skid_last_q;
        skid_data_d = skid_data_q;
        if (!head_v_q || pop) begin
            if (skid_v_q) begin
                head_v_d    = 1'b1;
                head_last_d = skid_last_q;
                head_data_d = skid_data_q;
                skid_v_d    = ram_valid_q;
                skid_last_d = ram_last_q;
                skid_data_d = ram_rdata;
            end else if (ram_valid_q) begin
                head_v_d    = 1'b1;
                head_last_d = ram_last_q;
                head_data_d = ram_rdata;
            end else begin
                head_v_d    = 1'b0;
                head_last_d = 1'b0;
            end
        end else if (ram_valid_q) begin
            skid_v_d    = 1'b1;
            skid_last_d = ram_last_q;
            skid_data_d = ram_rdata;
        end
    end

    assign full_d = (full_q | wr_set) & ~rd_clr;

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_state_q  <= W_FILL;
            wr_sel_q    <= 1'b0;
            wr_ptr_q    <= '0;
            full_q      <= 2'b00;
            len_q       <= '0;
            rev_q       <= {REV_OFF, REV_OFF};
            overflow_q  <= 1'b0;
            rd_state_q  <= R_IDLE;
            rd_sel_q    <= 1'b0;
            rd_cnt_q    <= '0;
            ram_valid_q <= 1'b0;
            ram_last_q  <= 1'b0;
            head_v_q    <= 1'b0;
            head_last_q <= 1'b0;
            head_data_q <= '0;
            skid_v_q    <= 1'b0;
            skid_last_q <= 1'b0;
            skid_data_q <= '0;
        end else begin
            wr_state_q  <= wr_state_d;
            wr_sel_q    <= wr_sel_d;
            wr_ptr_q    <= wr_ptr_d;
            full_q      <= full_d;
            len_q       <= len_d;
            rev_q       <= rev_d;
            overflow_q  <= overflow_d;
            rd_state_q  <= rd_state_d;
            rd_sel_q    <= rd_sel_d;
            rd_cnt_q    <= rd_cnt_d;
            ram_valid_q <= ram_re;
            ram_last_q  <= ram_last_d;
            head_v_q    <= head_v_d;
            head_last_q <= head_last_d;
            head_data_q <= head_data_d;
            skid_v_q    <= skid_v_d;
            skid_last_q <= skid_last_d;
            skid_data_q <= skid_data_d;
        end
    end

    assign s_axis_tready = s_ready && !areset;
    assign m_axis_tdata  = head_data_q;
    assign m_axis_tvalid = head_v_q;
    assign m_axis_tlast  = head_last_q;
    assign overflow      = overflow_q;
    assign bank_full     = full_q;

endmodule

// File: tb/tb_axis_pingpong_frame_buffer.sv
// Randomised bench for the ping-pong frame buffer, scored against a frame-level queue model.
module tb_axis_pingpong_frame_buffer;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic          cfg_reverse = 1'b0;
    logic [DW-1:0] s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic          s_axis_tlast = 1'b0;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    logic          m_axis_tlast;
    logic          overflow;
    logic [1:0]    bank_full;

    axis_pingpong_frame_buffer #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .cfg_reverse   (cfg_reverse),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .overflow      (overflow),
        .bank_full     (bank_full)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    int            n_checks = 0;
    int            n_fail = 0;
    int            cyc = 0;
    int            rdy_pct = 100;
    int            vld_pct = 100;
    int            exp_ovf = 0;
    int            ovf_cycles = 0;
    int            ovf_last_cyc = -1;
    int            out_beats = 0;
    int            last_span = -1;
    beat_t         exp_q[$];
    logic [DW-1:0] frame_q[$];
    int            acc_q[$];
    int            done_cyc[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    initial forever #5 aclk = ~aclk;

    initial forever begin
        @(posedge aclk);
        cyc++;
    end

    initial forever begin
        @(posedge aclk);
        #1;
        m_axis_tready = int'($urandom_range(99)) < rdy_pct;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Output monitor: samples mid-cycle, so a seen handshake completes on the next rising edge.
    initial begin
        beat_t         e;
        logic          prev_stall = 1'b0;
        logic [DW-1:0] prev_d = '0;
        logic          prev_l = 1'b0;
        logic          in_frame = 1'b0;
        int            fstart = 0;
        forever begin
            @(negedge aclk);
            if (areset) begin
                prev_stall = 1'b0;
                in_frame   = 1'b0;
            end else begin
                if (overflow) begin
                    ovf_cycles++;
                    ovf_last_cyc = cyc;
                end
                if (prev_stall) begin
                    check_eq("hold_valid", 64'(m_axis_tvalid), 1);
                    check_eq("hold_data", 64'(m_axis_tdata), 64'(prev_d));
                    check_eq("hold_last", 64'(m_axis_tlast), 64'(prev_l));
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        check_eq("out_extra_beat", 64'(m_axis_tvalid), 0);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("out_data", 64'(m_axis_tdata), 64'(e.data));
                        check_eq("out_last", 64'(m_axis_tlast), 64'(e.last));
                        out_beats++;
                        if (!in_frame) begin
                            fstart   = cyc;
                            in_frame = 1'b1;
                        end
                        if (m_axis_tlast) begin
                            last_span = cyc - fstart;
                            in_frame  = 1'b0;
                            done_cyc.push_back(cyc);
                        end
                    end
                end
                prev_stall = m_axis_tvalid && !m_axis_tready;
                prev_d     = m_axis_tdata;
                prev_l     = m_axis_tlast;
            end
        end
    end

    // Entered and left just after a rising edge.
    task automatic send_beat(input logic [DW-1:0] d, input logic last, output int acc_cyc);
        int waited;
        waited = 0;
        while (int'($urandom_range(99)) >= vld_pct) begin
            s_axis_tvalid = 1'b0;
            @(posedge aclk);
            #1;
        end
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        @(negedge aclk);
        while (!s_axis_tready && waited < 2000) begin
            waited++;
            @(negedge aclk);
        end
        check_eq("s_accept", 64'(s_axis_tready), 1);
        acc_cyc = cyc;
        @(posedge aclk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    // Model: the stored frame is the first DEPTH beats, replayed in order or reversed.
    task automatic send_frame(input bit rev);
        int n;
        int keep;
        int idx;
        int c;
        n    = frame_q.size();
        keep = (n > DEPTH) ? DEPTH : n;
        for (int i = 0; i < keep; i++) begin
            idx = rev ? keep - 1 - i : i;
            exp_q.push_back('{data: frame_q[idx], last: (i == keep - 1)});
        end
        if (n > DEPTH) exp_ovf++;
        acc_q.delete();
        cfg_reverse = rev;
        for (int i = 0; i < n; i++) begin
            send_beat(frame_q[i], i == n - 1, c);
            acc_q.push_back(c);
        end
    endtask

    task automatic make_frame(input int n, input int base, input bit rnd);
        frame_q.delete();
        for (int i = 0; i < n; i++) begin
            frame_q.push_back(rnd ? DW'($urandom) : DW'(base + i));
        end
    endtask

    task automatic drain(input string tag);
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 5000) begin
            @(posedge aclk);
            w++;
        end
        repeat (2) @(posedge aclk);
        #1;
        check_eq(tag, 64'(exp_q.size()), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_m_tvalid"}, 64'(m_axis_tvalid), 0);
        check_eq({tag, "_m_tlast"}, 64'(m_axis_tlast), 0);
        check_eq({tag, "_m_tdata"}, 64'(m_axis_tdata), 0);
        check_eq({tag, "_overflow"}, 64'(overflow), 0);
        check_eq({tag, "_bank_full"}, 64'(bank_full), 0);
        check_eq({tag, "_s_tready"}, 64'(s_axis_tready), 0);
    endtask

    initial begin
        int first_acc;
        int base;
        int w;

        // Power-on reset.
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check_reset_outputs("rst");
        @(posedge aclk);
        #1;
        areset = 1'b0;
        @(negedge aclk);
        check_eq("rst_s_tready_after", 64'(s_axis_tready), 1);
        @(posedge aclk);
        #1;

        // Full-depth ramp frame, forward, sink always ready: must leave without gaps.
        make_frame(DEPTH, 0, 1'b0);
        send_frame(1'b0);
        drain("drain_full_depth");
        check_eq("full_depth_span", 64'(last_span), 64'(DEPTH - 1));
        check_eq("full_depth_no_ovf", 64'(ovf_cycles), 0);

        // Reversed 4-beat frame, then a single-beat forward frame.
        frame_q = '{8'hA, 8'hB, 8'hC, 8'hD};
        send_frame(1'b1);
        frame_q = '{8'h5A};
        send_frame(1'b0);
        drain("drain_rev_single");

        // Both banks fill while the sink stalls; the third frame waits for the first to drain.
        rdy_pct = 0;
        @(posedge aclk);
        #1;
        make_frame(DEPTH, 16, 1'b0);
        send_frame(1'b0);
        make_frame(DEPTH, 64, 1'b0);
        send_frame(1'b1);
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check_eq("bp_s_tready_low", 64'(s_axis_tready), 0);
        check_eq("bp_bank_full", 64'(bank_full), 64'(2'b11));
        @(posedge aclk);
        #1;
        done_cyc.delete();
        rdy_pct = 100;
        make_frame(DEPTH, 128, 1'b0);
        send_frame(1'b0);
        first_acc = acc_q[0];
        drain("drain_bp");
        check_eq("bp_frames_out", 64'(done_cyc.size()), 3);
        check_eq("bp_f3_after_f1", 64'(done_cyc.size() > 0 && first_acc > done_cyc[0]), 1);

        // Overlong frame is truncated at DEPTH; the following frame is intact.
        make_frame(DEPTH + 3, 1, 1'b0);
        send_frame(1'b0);
        check_eq("ovf_timing", 64'(ovf_last_cyc), 64'(acc_q[DEPTH - 1] + 1));
        make_frame(5, 200, 1'b0);
        send_frame(1'b1);
        drain("drain_ovf");
        check_eq("ovf_pulses", 64'(ovf_cycles), 64'(exp_ovf));

        // Random lengths, modes and handshakes on both sides.
        rdy_pct = 50;
        vld_pct = 50;
        for (int f = 0; f < 20; f++) begin
            make_frame(int'($urandom_range(DEPTH, 1)), 0, 1'b1);
            send_frame(1'($urandom));
        end
        drain("drain_random");
        vld_pct = 100;

        // Reset while frame 1 is being sent and frame 2 is buffered.
        rdy_pct = 0;
        @(posedge aclk);
        #1;
        make_frame(DEPTH, 32, 1'b0);
        send_frame(1'b0);
        make_frame(10, 96, 1'b0);
        send_frame(1'b0);
        base    = out_beats;
        rdy_pct = 100;
        w       = 0;
        while (out_beats < base + 4 && w < 200) begin
            @(posedge aclk);
            w++;
        end
        #1;
        check_eq("rst_mid_progress", 64'(out_beats >= base + 4), 1);
        areset = 1'b1;
        exp_q.delete();
        @(posedge aclk);
        @(negedge aclk);
        check_reset_outputs("rst_mid");
        @(posedge aclk);
        #1;
        areset = 1'b0;
        repeat (20) @(posedge aclk);
        #1;
        check_eq("rst_mid_banks_empty", 64'(bank_full), 0);
        make_frame(6, 240, 1'b0);
        send_frame(1'b1);
        drain("drain_post_reset");

        check_eq("final_ovf_pulses", 64'(ovf_cycles), 64'(exp_ovf));
        check_eq("final_bank_full", 64'(bank_full), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
